// File: rtl/ram_clear_ctrl_if.sv
// Memory-side write ports driven by the RAM clear sequencer: the SDRAM single-word
// write port and the DDR3 Avalon-style burst write port.
interface ram_clear_ctrl_if #(
  parameter int unsigned SDR_AW = 25,
  parameter int unsigned DDR_AW = 29
);
  // SDRAM single-word write port
  logic              sdr_ready;
  logic              sdr_we;
  logic [SDR_AW-1:0] sdr_addr;
  logic [15:0]       sdr_din;

  // DDR3 burst write port
  logic              ddr_busy;
  logic              ddr_we;
  logic [DDR_AW-1:0] ddr_addr;
  logic [7:0]        ddr_burstcnt;
  logic [63:0]       ddr_din;
  logic [7:0]        ddr_be;

  modport master (
    input  sdr_ready,
    output sdr_we,
    output sdr_addr,
    output sdr_din,
    input  ddr_busy,
    output ddr_we,
    output ddr_addr,
    output ddr_burstcnt,
    output ddr_din,
    output ddr_be
  );

  modport slave (
    output sdr_ready,
    input  sdr_we,
    input  sdr_addr,
    input  sdr_din,
    output ddr_busy,
    input  ddr_we,
    input  ddr_addr,
    input  ddr_burstcnt,
    input  ddr_din,
    input  ddr_be
  );
endinterface

// File: rtl/ram_clear_ctrl.sv
// Clears SDRAM and DDR3 to a 64-bit fill pattern. The two channels run concurrently,
// each with its own address generator; busy/done report the state of the whole pass.
module ram_clear_ctrl #(
  parameter int unsigned SDR_AW    = 25,
  parameter int unsigned DDR_AW    = 29,
  parameter int unsigned DDR_BURST = 128
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              start,
  input  logic [63:0]       fill,
  input  logic [SDR_AW-1:0] sdr_last,
  input  logic [DDR_AW-1:0] ddr_last,
  ram_clear_ctrl_if.master  mem,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {SdrIdle, SdrRun, SdrFin} sdr_state_e;
  typedef enum logic [1:0] {DdrIdle, DdrBurst, DdrFin} ddr_state_e;

  localparam logic [7:0]        BurstMax  = 8'(DDR_BURST);
  localparam logic [DDR_AW:0]   BurstMaxW = (DDR_AW + 1)'(DDR_BURST);
  localparam logic [SDR_AW-1:0] SdrOne    = SDR_AW'(1);
  localparam logic [DDR_AW-1:0] DdrOne    = DDR_AW'(1);

  // Pass control
  logic [63:0]       fill_q, fill_d;
  logic [SDR_AW-1:0] sdr_last_q, sdr_last_d;
  logic [DDR_AW-1:0] ddr_last_q, ddr_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_ok;
  logic              all_fin;

  // SDRAM channel
  sdr_state_e        sdr_state_q, sdr_state_d;
  logic [SDR_AW-1:0] sdr_addr_q, sdr_addr_d;
  logic              sdr_we_q, sdr_we_d;

  // DDR3 channel
  ddr_state_e        ddr_state_q, ddr_state_d;
  logic [DDR_AW-1:0] ddr_addr_q, ddr_addr_d;
  logic [7:0]        ddr_cnt_q, ddr_cnt_d;
  logic [7:0]        ddr_beat_q, ddr_beat_d;
  logic              ddr_we_q, ddr_we_d;
  logic              ddr_accept;
  logic              ddr_last_beat;
  logic [DDR_AW-1:0] ddr_burst_end;
  logic [DDR_AW-1:0] ddr_next_addr;

  // Burst length from base to last inclusive, capped at DDR_BURST; one extra bit so
  // a full-range clear cannot wrap to zero.
  function automatic logic [7:0] burst_len(input logic [DDR_AW-1:0] base,
                                           input logic [DDR_AW-1:0] last);
    logic [DDR_AW:0] rem;
    rem = {1'b0, last} - {1'b0, base} + (DDR_AW + 1)'(1);
    burst_len = (rem >= BurstMaxW) ? BurstMax : 8'(rem);
  endfunction

  assign start_ok = start & ~busy_q;
  assign all_fin  = (sdr_state_q == SdrFin) && (ddr_state_q == DdrFin);

  // Pass control: latch pattern and limits on an accepted start, retire on completion
  always_comb begin
    fill_d     = fill_q;
    sdr_last_d = sdr_last_q;
    ddr_last_d = ddr_last_q;
    busy_d     = busy_q;
    done_d     = done_q;
    if (start_ok) begin
      fill_d     = fill;
      sdr_last_d = sdr_last;
      ddr_last_d = ddr_last;
      busy_d     = 1'b1;
      done_d     = 1'b0;
    end else if (all_fin) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  // Pass control registers
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      fill_q     <= '0;
      sdr_last_q <= '0;
      ddr_last_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      sdr_last_q <= sdr_last_d;
      ddr_last_q <= ddr_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // SDRAM state register
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      sdr_state_q <= SdrIdle;
      sdr_addr_q  <= '0;
      sdr_we_q    <= 1'b0;
    end else begin
      sdr_state_q <= sdr_state_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_we_q    <= sdr_we_d;
    end
  end

  // SDRAM next state: strobe, then advance on the cycle after, so at most one write per 2 cycles
  always_comb begin
    sdr_state_d = sdr_state_q;
    sdr_addr_d  = sdr_addr_q;
    sdr_we_d    = 1'b0;
    unique case (sdr_state_q)
      SdrIdle: begin
        if (start_ok) begin
          sdr_state_d = SdrRun;
          sdr_addr_d  = '0;
        end
      end
      SdrRun: begin
        if (sdr_we_q) begin
          if (sdr_addr_q == sdr_last_q) begin
            sdr_state_d = SdrFin;
          end else begin
            sdr_addr_d = sdr_addr_q + SdrOne;
          end
        end else if (mem.sdr_ready) begin
          sdr_we_d = 1'b1;
        end
      end
      SdrFin: begin
        if (all_fin) begin
          sdr_state_d = SdrIdle;
        end
      end
      default: sdr_state_d = SdrIdle;
    endcase
  end

  assign ddr_accept    = ddr_we_q & ~mem.ddr_busy;
  assign ddr_last_beat = (ddr_beat_q == ddr_cnt_q - 8'd1);
  assign ddr_next_addr = ddr_addr_q + DDR_AW'(ddr_cnt_q);
  assign ddr_burst_end = ddr_next_addr - DdrOne;

  // DDR3 state register
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      ddr_state_q <= DdrIdle;
      ddr_addr_q  <= '0;
      ddr_cnt_q   <= '0;
      ddr_beat_q  <= '0;
      ddr_we_q    <= 1'b0;
    end else begin
      ddr_state_q <= ddr_state_d;
      ddr_addr_q  <= ddr_addr_d;
      ddr_cnt_q   <= ddr_cnt_d;
      ddr_beat_q  <= ddr_beat_d;
      ddr_we_q    <= ddr_we_d;
    end
  end

  // DDR3 next state: bursts chain back-to-back until the burst ending at ddr_last completes
  always_comb begin
    ddr_state_d = ddr_state_q;
    ddr_addr_d  = ddr_addr_q;
    ddr_cnt_d   = ddr_cnt_q;
    ddr_beat_d  = ddr_beat_q;
    ddr_we_d    = ddr_we_q;
    unique case (ddr_state_q)
      DdrIdle: begin
        if (start_ok) begin
          // Limit comes straight from the port as it is latched on this same edge
          ddr_state_d = DdrBurst;
          ddr_addr_d  = '0;
          ddr_cnt_d   = burst_len('0, ddr_last);
          ddr_beat_d  = '0;
          ddr_we_d    = 1'b1;
        end
      end
      DdrBurst: begin
        if (ddr_accept) begin
          if (!ddr_last_beat) begin
            ddr_beat_d = ddr_beat_q + 8'd1;
          end else if (ddr_burst_end == ddr_last_q) begin
            ddr_state_d = DdrFin;
            ddr_we_d    = 1'b0;
          end else begin
            ddr_addr_d = ddr_next_addr;
            ddr_cnt_d  = burst_len(ddr_next_addr, ddr_last_q);
            ddr_beat_d = '0;
          end
        end
      end
      DdrFin: begin
        if (all_fin) begin
          ddr_state_d = DdrIdle;
        end
      end
      default: ddr_state_d = DdrIdle;
    endcase
  end

  // Outputs: everything is registered state; only the SDRAM data lane is selected here
  always_comb begin
    mem.sdr_we = sdr_we_q;
    mem.sdr_addr = sdr_addr_q;
    unique case (sdr_addr_q[1:0])
      2'd0: mem.sdr_din = fill_q[15:0];
      2'd1: mem.sdr_din = fill_q[31:16];
      2'd2: mem.sdr_din = fill_q[47:32];
      2'd3: mem.sdr_din = fill_q[63:48];
      default: mem.sdr_din = '0;
    endcase
    mem.ddr_we       = ddr_we_q;
    mem.ddr_addr     = ddr_addr_q;
    mem.ddr_burstcnt = ddr_cnt_q;
    mem.ddr_din      = fill_q;
    mem.ddr_be       = ddr_we_q ? 8'hFF : 8'h00;
    busy             = busy_q;
    done             = done_q;
  end

endmodule

// File: tb/tb_ram_clear_ctrl.sv
// Directed bench for ram_clear_ctrl with DDR_BURST=4: plain clear, DDR backpressure,
// ignored start while busy, abort by reset and restart with a single-word SDRAM range.
module tb_ram_clear_ctrl;

  localparam int unsigned SDR_AW = 25;
  localparam int unsigned DDR_AW = 29;
  localparam logic [63:0] Fill   = 64'h4444_3333_2222_1111;

  logic              clk_sys;
  logic              RESET;
  logic              start;
  logic [63:0]       fill;
  logic [SDR_AW-1:0] sdr_last;
  logic [DDR_AW-1:0] ddr_last;
  logic              busy;
  logic              done;

  int    n_cmp;
  int    n_bad;
  string ctx;
  int    cyc;

  logic [15:0] din_tab [4];

  ram_clear_ctrl_if #(.SDR_AW(SDR_AW), .DDR_AW(DDR_AW)) mem_if ();

  ram_clear_ctrl #(
    .SDR_AW   (SDR_AW),
    .DDR_AW   (DDR_AW),
    .DDR_BURST(4)
  ) dut (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .start   (start),
    .fill    (fill),
    .sdr_last(sdr_last),
    .ddr_last(ddr_last),
    .mem     (mem_if),
    .busy    (busy),
    .done    (done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s/%s c=%0d: observed %0h expected %0h", ctx, name, cyc, obs, exp);
    end
  endtask

  // Drive a start pulse for the next edge with sdr_n SDRAM words and DDR limit 9
  task automatic kick(input int sdr_n);
    fill     = Fill;
    sdr_last = SDR_AW'(sdr_n - 1);
    ddr_last = DDR_AW'(9);
    start    = 1'b1;
  endtask

  // Observe cycles 1..last_c after the start edge against the hand-derived timeline:
  // SDRAM writes on even cycles, DDR bursts (0,4),(4,4),(8,2) starting at cycles 1, b1, b2
  // with ddr_we high through hi_end; ddr_busy driven high for cycles stall_lo..stall_hi.
  task automatic run_pass(input int sdr_n, input int b1, input int b2, input int hi_end,
                          input int stall_lo, input int stall_hi, input int ign_at,
                          input int last_c, input string tag);
    int         sdr_fin_c;
    int         done_c;
    int         we_cnt;
    int         acc_cnt;
    int         wr_cnt;
    logic       ddr_on;
    logic       sdr_on;
    logic [7:0] exp_cnt;
    int         exp_addr;
    ctx       = tag;
    sdr_fin_c = 2 * sdr_n + 1;
    done_c    = ((sdr_fin_c > hi_end + 1) ? sdr_fin_c : hi_end + 1) + 1;
    we_cnt    = 0;
    acc_cnt   = 0;
    wr_cnt    = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk_sys);
      cyc = c;
      ddr_on = (c <= hi_end);
      chk("ddr_we", 64'(mem_if.ddr_we), 64'(ddr_on));
      if (ddr_on) begin
        if (c < b1) begin
          exp_addr = 0;
          exp_cnt  = 8'd4;
        end else if (c < b2) begin
          exp_addr = 4;
          exp_cnt  = 8'd4;
        end else begin
          exp_addr = 8;
          exp_cnt  = 8'd2;
        end
        chk("ddr_addr", 64'(mem_if.ddr_addr), 64'(exp_addr));
        chk("ddr_burstcnt", 64'(mem_if.ddr_burstcnt), 64'(exp_cnt));
        chk("ddr_din", mem_if.ddr_din, Fill);
        chk("ddr_be", 64'(mem_if.ddr_be), 64'h0FF);
      end
      sdr_on = ((c % 2) == 0) && (c <= 2 * sdr_n);
      chk("sdr_we", 64'(mem_if.sdr_we), 64'(sdr_on));
      if (sdr_on) begin
        chk("sdr_addr", 64'(mem_if.sdr_addr), 64'(c / 2 - 1));
        chk("sdr_din", 64'(mem_if.sdr_din), 64'(din_tab[(c / 2 - 1) % 4]));
      end
      chk("busy", 64'(busy), 64'(c < done_c));
      chk("done", 64'(done), 64'(c >= done_c));
      // Inputs for the coming edge; a start here must be ignored as the pass is busy
      start    = (c == ign_at);
      sdr_last = (c == ign_at) ? SDR_AW'(1) : SDR_AW'(sdr_n - 1);
      ddr_last = (c == ign_at) ? DDR_AW'(1) : DDR_AW'(9);
      fill     = (c == ign_at) ? 64'h0 : Fill;
      mem_if.ddr_busy = (c >= stall_lo) && (c <= stall_hi);
      if (mem_if.ddr_we) we_cnt++;
      if (mem_if.ddr_we && !mem_if.ddr_busy) acc_cnt++;
      if (mem_if.sdr_we) wr_cnt++;
    end
    mem_if.ddr_busy = 1'b0;
    if (last_c >= done_c) begin
      cyc = last_c;
      chk("ddr_we_cycles", 64'(we_cnt), 64'(hi_end));
      chk("ddr_beats", 64'(acc_cnt), 64'd10);
      chk("sdr_writes", 64'(wr_cnt), 64'(sdr_n));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    din_tab[0] = 16'h1111;
    din_tab[1] = 16'h2222;
    din_tab[2] = 16'h3333;
    din_tab[3] = 16'h4444;

    // Reset held for 3 edges with random inputs
    ctx = "reset";
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start           = 1'($urandom);
      fill            = {$urandom, $urandom};
      sdr_last        = SDR_AW'($urandom);
      ddr_last        = DDR_AW'($urandom);
      mem_if.sdr_ready = 1'($urandom);
      mem_if.ddr_busy  = 1'($urandom);
      @(negedge clk_sys);
    end
    chk("sdr_we", 64'(mem_if.sdr_we), 64'd0);
    chk("ddr_we", 64'(mem_if.ddr_we), 64'd0);
    chk("busy", 64'(busy), 64'd0);
    chk("done", 64'(done), 64'd0);
    chk("sdr_addr", 64'(mem_if.sdr_addr), 64'd0);
    chk("ddr_burstcnt", 64'(mem_if.ddr_burstcnt), 64'd0);
    chk("ddr_be", 64'(mem_if.ddr_be), 64'd0);

    RESET            = 1'b1;
    start            = 1'b0;
    fill             = Fill;
    sdr_last         = SDR_AW'(5);
    ddr_last         = DDR_AW'(9);
    mem_if.sdr_ready = 1'b1;
    mem_if.ddr_busy  = 1'b0;
    @(negedge clk_sys);
    chk("idle_busy", 64'(busy), 64'd0);

    // Plain pass with a start pulse mid-pass carrying different limits and pattern
    kick(6);
    run_pass(6, 5, 9, 10, 0, 0, 5, 17, "pass1");

    // Same pass with ddr_busy held on beat 2 of the first burst for 3 cycles
    kick(6);
    run_pass(6, 8, 12, 13, 2, 4, 0, 17, "stall");

    // Abort by reset during the second DDR burst
    kick(6);
    run_pass(6, 5, 9, 10, 0, 0, 0, 5, "abort");
    @(negedge clk_sys);
    cyc = 6;
    chk("ddr_we_pre", 64'(mem_if.ddr_we), 64'd1);
    chk("ddr_addr_pre", 64'(mem_if.ddr_addr), 64'd4);
    RESET = 1'b0;
    @(negedge clk_sys);
    cyc = 7;
    chk("ddr_we", 64'(mem_if.ddr_we), 64'd0);
    chk("busy", 64'(busy), 64'd0);
    chk("done", 64'(done), 64'd0);
    chk("sdr_we", 64'(mem_if.sdr_we), 64'd0);
    chk("ddr_addr", 64'(mem_if.ddr_addr), 64'd0);
    chk("ddr_burstcnt", 64'(mem_if.ddr_burstcnt), 64'd0);
    RESET = 1'b1;
    @(negedge clk_sys);

    // Restart from address 0 with sdr_last=0: exactly one SDRAM write
    kick(1);
    run_pass(1, 5, 9, 10, 0, 0, 0, 15, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
